writeback_scoreboard: RTL
=========================

// Module: writeback_scoreboard
// PURPOSE
//  MIPS pipeline WB stage and register-file write side, paired with the decode-stage register reads.
//  - Holds the MEM/WB pipeline register.
//  - Selects the ALU result or the load data, and drives the RegisterFile write port.
//  - Keeps a per-register pending-write scoreboard for decode RAW-hazard stalls.
//  - Bypasses the same-cycle write value to the decode read ports (write-before-read).
// PARAMETERS
//  CNT_W     2   width of each pending-write counter (max in-flight writes per reg = 2^CNT_W-1)
//  NUM_REGS  32  architectural registers; reg 0 is hardwired zero
// PORTS
//  Clk            in   1   clock, all state updates on posedge
//  Rst_n          in   1   synchronous active-low reset
//  IssueValid     in   1   decode issues an instruction this cycle
//  IssueRegWrite  in   1   issued instruction writes a register (ControlLines[11])
//  IssueDest      in   5   destination register of the issued instruction
//  MemValid       in   1   MEM stage holds a valid instruction
//  MemControl     in   12  MEM-stage ControlLines (bit 11 RegWrite, bit 4 MemtoReg)
//  MemAluResult   in   32  ALU result from MEM stage
//  MemReadData    in   32  data-memory load data
//  MemWriteReg    in   5   destination register from MEM stage
//  ReadReg1/2     in   5   decode read addresses
//  RegData1/2     in   32  raw RegisterFile read data
//  WriteReg       out  5   RegisterFile write address
//  WriteData      out  32  RegisterFile write data
//  writeregenable out  1   RegisterFile write enable
//  BypData1/2     out  32  forwarded read data to decode
//  Busy           out  32  Busy[r]=1 while writes to r are pending
//  SbError        out  1   sticky scoreboard over/underflow flag
// BEHAVIOUR
//  Reset (Rst_n=0 at posedge):
//  - wb_valid=0; WB regs=0; all counters=0; SbError=0.
//  - Hence writeregenable=0, WriteReg=0, WriteData=0 and Busy=0.
//  MEM/WB register:
//  - Every posedge, captures MemValid, RegWrite, MemtoReg, MemAluResult, MemReadData and MemWriteReg.
//  - No stall or flush input: the WB stage always advances; a bubble is MemValid=0.
//  Write port (combinational from WB regs; latency is one cycle MEM->WB, with the regfile written at the following posedge):
//  - writeregenable = wb_valid & wb_regwrite & (wb_dest!=0).
//  - WriteData = wb_memtoreg ? wb_memdata : wb_alu.
//  - WriteReg = wb_dest.
//  Retire event: retire = writeregenable, with retire target wb_dest.
//  Issue event: issue = IssueValid & IssueRegWrite & (IssueDest!=0).
//  Scoreboard, per register r in 1..31 at posedge:
//  - cnt[r] += issue hit on r; cnt[r] -= retire hit on r.
//  - Issue and retire both hitting r in the same cycle: cnt[r] unchanged.
//  - Issue hitting r with cnt[r] at its maximum (no retire on r): cnt holds, SbError<=1.
//  - Retire hitting r with cnt[r]==0 (no issue on r): cnt stays 0, SbError<=1.
//  - SbError is cleared only by reset.
//  Busy output:
//  - Busy[r] = (cnt[r]!=0), registered state only; it does not include the same-cycle issue.
//  - Busy[0] = 0 always.
//  Bypass:
//  - BypDataN = (writeregenable && WriteReg==ReadRegN) ? WriteData : RegDataN.
//  - Reg 0 is never bypassed.
//  Reset mid-operation: all in-flight pending counts are discarded; the pipeline must also be flushed by reset.
// STRUCTURE
//  Shared package mips_pkg:
//  - CL_REGWRITE=11, CL_MEMTOREG=4, CL_BRANCH=2, CL_REGDST=0.
//  - REG_AW=5, DATA_W=32, NUM_REGS=32.
//  Sub-module sb_counter:
//  - One CNT_W-bit saturating up/down counter with inc, dec, busy and err outputs.
//  - Generated for r=1..31.
//  - Top level ORs the err outputs into the SbError set term.
// TESTING
//  1 Reset: Rst_n=0 for 2 cycles with random inputs -> writeregenable=0, Busy=0, SbError=0.
//  2 ALU write:
//    - Issue dest=8 at cycle 0 -> Busy[8]=1 from cycle 1.
//    - MEM presents RegWrite=1, MemtoReg=0, Alu=0x00001234, dest=8 -> next cycle writeregenable=1, WriteReg=8, WriteData=0x00001234.
//    - Busy[8]=0 after that posedge.
//  3 Load bypass: MEM presents MemtoReg=1, ReadData=0xDEADBEEF, dest=9; in the WB cycle ReadReg1=9, RegData1=0 -> WriteData=BypData1=0xDEADBEEF.
//  4 Simultaneous events: cnt[5]=1; issue r5 and retire r5 in the same cycle -> cnt[5]=1, Busy[5]=1, SbError=0.
//  5 Zero register: issue dest=0 and retire dest=0 with RegWrite=1 -> writeregenable=0, Busy[0]=0, no bypass on ReadReg1=0.
//  6 Error cases (CNT_W=2):
//    - Four issues to r3 with no retire -> cnt[3]=3, SbError=1.
//    - After reset, retire r3 with cnt=0 -> SbError=1 and it stays set.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: ControlLines bit positions, datapath widths,
// and the MEM/WB pipeline register layout used by the writeback stage.
package mips_pkg;

    localparam int CL_REGWRITE = 11;
    localparam int CL_MEMTOREG = 4;
    localparam int CL_BRANCH   = 2;
    localparam int CL_REGDST   = 0;

    localparam int CTRL_W   = 12;
    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memtoreg;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] memdata;
        logic [REG_AW-1:0] dest;
    } wb_reg_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating pending-write counter for one architectural register.
// err flags an attempted overflow or underflow in the current cycle.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A simultaneous inc and dec cancel, so only one-sided events move the count.
    always_comb begin
        cnt_d = cnt_q;
        err   = 1'b0;
        if (inc && !dec) begin
            if (cnt_q == CNT_MAX) begin
                err = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (cnt_q == '0) begin
                err = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/writeback_scoreboard.sv
// MIPS WB stage: MEM/WB register, register-file write port, per-register
// pending-write scoreboard and write-before-read bypass to the decode reads.
module writeback_scoreboard #(
    parameter int CNT_W    = 2,
    parameter int NUM_REGS = 32
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         IssueValid,
    input  logic                         IssueRegWrite,
    input  logic [mips_pkg::REG_AW-1:0]  IssueDest,
    input  logic                         MemValid,
    input  logic [mips_pkg::CTRL_W-1:0]  MemControl,
    input  logic [mips_pkg::DATA_W-1:0]  MemAluResult,
    input  logic [mips_pkg::DATA_W-1:0]  MemReadData,
    input  logic [mips_pkg::REG_AW-1:0]  MemWriteReg,
    input  logic [mips_pkg::REG_AW-1:0]  ReadReg1,
    input  logic [mips_pkg::REG_AW-1:0]  ReadReg2,
    input  logic [mips_pkg::DATA_W-1:0]  RegData1,
    input  logic [mips_pkg::DATA_W-1:0]  RegData2,
    output logic [mips_pkg::REG_AW-1:0]  WriteReg,
    output logic [mips_pkg::DATA_W-1:0]  WriteData,
    output logic                         writeregenable,
    output logic [mips_pkg::DATA_W-1:0]  BypData1,
    output logic [mips_pkg::DATA_W-1:0]  BypData2,
    output logic [NUM_REGS-1:0]          Busy,
    output logic                         SbError
);

    import mips_pkg::*;

    wb_reg_t wb_q;
    wb_reg_t wb_d;
    logic    sb_error_q;
    logic    sb_error_d;

    logic issue;
    logic retire;
    logic unused_ctrl;

    logic [NUM_REGS-1:1] inc_vec;
    logic [NUM_REGS-1:1] dec_vec;
    logic [NUM_REGS-1:1] busy_vec;
    logic [NUM_REGS-1:1] err_vec;

    // No stall or flush: the WB stage takes whatever MEM holds every cycle.
    always_comb begin
        wb_d          = wb_q;
        wb_d.valid    = MemValid;
        wb_d.regwrite = MemControl[CL_REGWRITE];
        wb_d.memtoreg = MemControl[CL_MEMTOREG];
        wb_d.alu      = MemAluResult;
        wb_d.memdata  = MemReadData;
        wb_d.dest     = MemWriteReg;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wb_q       <= '0;
            sb_error_q <= 1'b0;
        end else begin
            wb_q       <= wb_d;
            sb_error_q <= sb_error_d;
        end
    end

    assign writeregenable = wb_q.valid && wb_q.regwrite && (wb_q.dest != '0);
    assign WriteReg       = wb_q.dest;
    assign WriteData      = wb_q.memtoreg ? wb_q.memdata : wb_q.alu;

    assign issue  = IssueValid && IssueRegWrite && (IssueDest != '0);
    assign retire = writeregenable;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_vec[r] = issue  && (IssueDest == REG_AW'(r));
            dec_vec[r] = retire && (wb_q.dest == REG_AW'(r));
        end
    end

    // Register 0 is hardwired zero, so it never gets a counter.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (Clk),
            .rst_n (Rst_n),
            .inc   (inc_vec[r]),
            .dec   (dec_vec[r]),
            .busy  (busy_vec[r]),
            .err   (err_vec[r])
        );
    end

    assign sb_error_d = sb_error_q | (|err_vec);
    assign SbError    = sb_error_q;
    assign Busy       = {busy_vec, 1'b0};

    assign BypData1 = (writeregenable && (WriteReg == ReadReg1)) ? WriteData : RegData1;
    assign BypData2 = (writeregenable && (WriteReg == ReadReg2)) ? WriteData : RegData2;

    assign unused_ctrl = ^{MemControl[CL_REGWRITE-1:CL_MEMTOREG+1],
                           MemControl[CL_MEMTOREG-1:CL_BRANCH],
                           MemControl[CL_BRANCH-1:CL_REGDST]};

endmodule
